// File: rtl/muldiv_unit.sv
// RV32M-style multiply/divide unit.
// Multiplies take one compute cycle; divides use a radix-2 restoring
// divider on operand magnitudes with a final sign-fix cycle.
// Divide-by-zero and signed overflow results are produced immediately.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] res_o,
   output logic            busy_o
);

   localparam int CW = ($clog2(XLEN + 1) > 6) ? $clog2(XLEN + 1) : 6;
   localparam logic [CW-1:0]   LAST     = CW'(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state, state_next;

   logic [2:0]      op_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] res_q;
   logic [CW-1:0]   cnt;
   logic            q_neg;
   logic            r_neg;

   logic            req_signed;
   logic            div_by_zero;
   logic            div_ovf;
   logic            div_special;
   logic [XLEN-1:0] special_res;
   logic            op1_neg;
   logic            op2_neg;
   logic [XLEN-1:0] op1_mag;
   logic [XLEN-1:0] op2_mag;

   logic              mul_a_sign;
   logic              mul_b_sign;
   logic [2*XLEN-1:0] mul_a_ext;
   logic [2*XLEN-1:0] mul_b_ext;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   mul_res;

   logic [XLEN:0]   shifted;
   logic            fits;
   logic [XLEN-1:0] rem_step;
   logic [XLEN-1:0] quo_step;
   logic [XLEN-1:0] div_res;

   // Decode the incoming request: special divide cases and operand magnitudes.
   always_comb begin
      req_signed  = ~op_i[0];
      div_by_zero = (op2_i == '0);
      div_ovf     = req_signed & (op1_i == MOST_NEG) & (op2_i == '1);
      div_special = op_i[2] & (div_by_zero | div_ovf);
      if (div_by_zero) begin
         special_res = op_i[1] ? op1_i : '1;
      end else begin
         special_res = op_i[1] ? '0 : op1_i;
      end
      op1_neg = req_signed & op1_i[XLEN-1];
      op2_neg = req_signed & op2_i[XLEN-1];
      op1_mag = op1_neg ? ('0 - op1_i) : op1_i;
      op2_mag = op2_neg ? ('0 - op2_i) : op2_i;
   end

   // Full-width product of the registered operands, sign-extended per op.
   always_comb begin
      mul_a_sign = a_q[XLEN-1] & (op_q[1:0] != 2'b11);
      mul_b_sign = b_q[XLEN-1] & (op_q[1:0] == 2'b01);
      mul_a_ext  = {{XLEN{mul_a_sign}}, a_q};
      mul_b_ext  = {{XLEN{mul_b_sign}}, b_q};
      product    = mul_a_ext * mul_b_ext;
      mul_res    = (op_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
   end

   // One restoring-division step plus the final sign correction.
   always_comb begin
      shifted  = {rem_q, quo_q[XLEN-1]};
      fits     = (shifted >= {1'b0, b_q});
      rem_step = fits ? (shifted[XLEN-1:0] - b_q) : shifted[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], fits};
      if (op_q[1]) begin
         div_res = r_neg ? ('0 - rem_q) : rem_q;
      end else begin
         div_res = q_neg ? ('0 - quo_q) : quo_q;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection; a flush returns to IDLE from anywhere.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (valid_i) begin
               if (!op_i[2]) begin
                  state_next = MUL;
               end else if (div_special) begin
                  state_next = DONE;
               end else begin
                  state_next = DIV;
               end
            end
         end
         MUL:  state_next = DONE;
         DIV:  state_next = (cnt == LAST) ? DONE : DIV;
         DONE: state_next = ready_i ? IDLE : DONE;
         default: state_next = IDLE;
      endcase
      if (flush_i) begin
         state_next = IDLE;
      end
   end

   // Handshake and status outputs follow directly from the state.
   always_comb begin
      ready_o = (state == IDLE) & ~flush_i;
      valid_o = (state == DONE);
      busy_o  = (state != IDLE);
      res_o   = res_q;
   end

   // Operand capture, iteration and result registers; a flush leaves them untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         quo_q <= '0;
         rem_q <= '0;
         res_q <= '0;
         cnt   <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (!flush_i) begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  op_q  <= op_i;
                  a_q   <= op1_i;
                  cnt   <= '0;
                  rem_q <= '0;
                  q_neg <= op1_neg ^ op2_neg;
                  r_neg <= op1_neg;
                  if (op_i[2]) begin
                     b_q   <= op2_mag;
                     quo_q <= op1_mag;
                     if (div_special) begin
                        res_q <= special_res;
                     end
                  end else begin
                     b_q <= op2_i;
                  end
               end
            end
            MUL: begin
               res_q <= mul_res;
            end
            DIV: begin
               if (cnt == LAST) begin
                  res_q <= div_res;
               end else begin
                  rem_q <= rem_step;
                  quo_q <= quo_step;
                  cnt   <= cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
